// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO: buffers {pc, inst} pairs, presents the oldest
// as a first-word-fall-through head, and empties in one cycle on branch mispredict.
module inst_queue #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_mispredict,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic [31:0]      fetch_inst,
  output logic             fetch_ready,
  input  logic             dispatch_ready,
  output logic             valid_inst,
  output logic [63:0]      queue_packet,
  output logic [PTR_W:0]   count
);

  logic [63:0]    mem_q [DEPTH];
  logic [PTR_W:0] head_q, head_d;
  logic [PTR_W:0] tail_q, tail_d;
  logic [PTR_W:0] count_q, count_d;
  logic           empty, full, push, pop;

  // The extra top bit separates "same slot, same lap" (empty) from "same slot, one lap ahead" (full).
  assign empty = (head_q == tail_q);
  assign full  = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) && (head_q[PTR_W] != tail_q[PTR_W]);

  assign fetch_ready  = !full;
  assign valid_inst   = !empty;
  assign push         = fetch_valid && !full && !branch_mispredict;
  assign pop          = !empty && dispatch_ready && !branch_mispredict;
  assign queue_packet = empty ? 64'h0 : mem_q[head_q[PTR_W-1:0]];
  assign count        = count_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (branch_mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q[PTR_W-1:0]] <= {fetch_pc, fetch_inst};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push && full));
      assert (!(pop && empty));
      assert (count_q <= (PTR_W+1)'(DEPTH));
      assert (count_q == (tail_q - head_q));
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue: fill/drain, streaming across wrap,
// full with simultaneous push/pop, mispredict flush and mid-stream reset.
module tb_inst_queue;

  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             branch_mispredict;
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_inst;
  logic             fetch_ready;
  logic             dispatch_ready;
  logic             valid_inst;
  logic [63:0]      queue_packet;
  logic [PTR_W:0]   count;

  int total = 0;
  int bad   = 0;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .branch_mispredict (branch_mispredict),
    .fetch_valid       (fetch_valid),
    .fetch_pc          (fetch_pc),
    .fetch_inst        (fetch_inst),
    .fetch_ready       (fetch_ready),
    .dispatch_ready    (dispatch_ready),
    .valid_inst        (valid_inst),
    .queue_packet      (queue_packet),
    .count             (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drive_push(input logic [31:0] pc, input logic [31:0] inst);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_inst  = inst;
  endtask

  initial begin
    rst               = 1'b0;
    branch_mispredict = 1'b0;
    fetch_valid       = 1'b0;
    fetch_pc          = '0;
    fetch_inst        = '0;
    dispatch_ready    = 1'b0;

    // Reset then idle
    tick();
    rst = 1'b1;
    tick();
    check("rst_valid", 64'(valid_inst), 64'd0);
    check("rst_packet", queue_packet, 64'h0);
    check("rst_ready", 64'(fetch_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);

    // Fill 16 with no dispatch
    for (int i = 0; i < 16; i++) begin
      drive_push(32'h1000 + 32'(4 * i), 32'h13 + 32'(i));
      tick();
    end
    check("fill_count", 64'(count), 64'd16);
    check("fill_ready", 64'(fetch_ready), 64'd0);
    check("fill_head", queue_packet, {32'h1000, 32'h13});
    drive_push(32'h1040, 32'h23);
    tick();
    check("overfill_count", 64'(count), 64'd16);
    fetch_valid = 1'b0;

    // Drain in order
    dispatch_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", 64'(valid_inst), 64'd1);
      check("drain_packet", queue_packet, {32'h1000 + 32'(4 * i), 32'h13 + 32'(i)});
      tick();
    end
    check("drain_count", 64'(count), 64'd0);
    check("drain_valid_end", 64'(valid_inst), 64'd0);
    check("drain_packet_end", queue_packet, 64'h0);

    // Steady stream: push and pop every cycle, crossing index wrap twice
    for (int i = 0; i <= 40; i++) begin
      if (i == 0) check("stream_empty", 64'(valid_inst), 64'd0);
      else check("stream_packet", queue_packet, {32'h3000 + 32'(4 * (i - 1)), 32'hA000 + 32'(i - 1)});
      drive_push(32'h3000 + 32'(4 * i), 32'hA000 + 32'(i));
      tick();
      check("stream_count", 64'(count), 64'd1);
    end
    fetch_valid = 1'b0;
    check("stream_last", queue_packet, {32'h3000 + 32'(4 * 40), 32'hA000 + 32'd40});
    tick();
    check("stream_drained", 64'(count), 64'd0);

    // Full plus simultaneous push/pop
    dispatch_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_push(32'h4000 + 32'(4 * i), 32'h100 + 32'(i));
      tick();
    end
    check("full2_count", 64'(count), 64'd16);
    drive_push(32'h5000, 32'h200);
    dispatch_ready = 1'b1;
    check("full2_ready", 64'(fetch_ready), 64'd0);
    tick();
    check("full_pp_count", 64'(count), 64'd15);
    check("full_pp_ready", 64'(fetch_ready), 64'd1);
    drive_push(32'h5004, 32'h201);
    tick();
    check("pp_count", 64'(count), 64'd15);
    fetch_valid = 1'b0;
    for (int i = 2; i < 16; i++) begin
      check("full_drain", queue_packet, {32'h4000 + 32'(4 * i), 32'h100 + 32'(i)});
      tick();
    end
    check("full_drain_tail", queue_packet, {32'h5004, 32'h201});
    tick();
    check("full_drain_count", 64'(count), 64'd0);

    // Branch mispredict with 5 entries
    dispatch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_push(32'h6000 + 32'(4 * i), 32'h300 + 32'(i));
      tick();
    end
    check("pre_flush_count", 64'(count), 64'd5);
    drive_push(32'h7000, 32'h3FF);
    dispatch_ready    = 1'b1;
    branch_mispredict = 1'b1;
    tick();
    branch_mispredict = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(valid_inst), 64'd0);
    check("flush_packet", queue_packet, 64'h0);
    check("flush_ready", 64'(fetch_ready), 64'd1);
    drive_push(32'h7004, 32'h301);
    dispatch_ready = 1'b0;
    check("post_flush_no_bypass", 64'(valid_inst), 64'd0);
    tick();
    fetch_valid = 1'b0;
    check("post_flush_valid", 64'(valid_inst), 64'd1);
    check("post_flush_packet", queue_packet, {32'h7004, 32'h301});
    check("post_flush_count", 64'(count), 64'd1);
    dispatch_ready = 1'b1;
    tick();
    check("post_flush_drained", 64'(count), 64'd0);

    // Reset mid-stream with 9 entries
    dispatch_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_push(32'h8000 + 32'(4 * i), 32'h500 + 32'(i));
      tick();
    end
    check("pre_rst_count", 64'(count), 64'd9);
    drive_push(32'h9000, 32'h600);
    dispatch_ready = 1'b1;
    rst = 1'b0;
    tick();
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_valid", 64'(valid_inst), 64'd0);
    check("mid_rst_ready", 64'(fetch_ready), 64'd1);
    check("mid_rst_packet", queue_packet, 64'h0);
    rst = 1'b1;
    dispatch_ready = 1'b0;
    drive_push(32'h2000, 32'h400);
    tick();
    fetch_valid = 1'b0;
    check("after_rst_packet", queue_packet, {32'h2000, 32'h400});
    check("after_rst_count", 64'(count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
